saturn_alu_sequencer: RTL and testbench

Nibble-serial sequencer for the Saturn ALU. It accepts one ALU operation described by an opcode, a begin/end nibble pointer pair and a carry-in. It then steps the ALU through each nibble position from begin to end, wrapping modulo 16, and chains the carry between nibbles. It streams each result nibble to the register write port and reports the final carry. It sits between the instruction decoder, which issues the operation, and the combinational ALU, which receives `run`/`done`/`calc_pos`/`prep_carry` from this block.

---
 rtl/saturn_alu_sequencer.sv | 122 ++++++++++++
 tb/tb_saturn_alu_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/saturn_alu_sequencer.sv
// Nibble-serial sequencer for the Saturn ALU: walks begin..end (mod NIBBLES),
// chains the carry between nibbles and streams each result nibble to the register file.
module saturn_alu_sequencer #(
  parameter  int NIBBLES = 16,
  localparam int PW      = $clog2(NIBBLES)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_clk_en,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic [4:0]    i_opcode,
  input  logic [PW-1:0] i_ptr_begin,
  input  logic [PW-1:0] i_ptr_end,
  input  logic          i_carry_in,
  input  logic [3:0]    i_calc_res_1_val,
  input  logic          i_calc_carry,
  output logic          o_busy,
  output logic [4:0]    o_alu_opcode,
  output logic          o_run,
  output logic          o_done,
  output logic [PW-1:0] o_calc_pos,
  output logic          o_prep_carry,
  output logic          o_wr_en,
  output logic [PW-1:0] o_wr_pos,
  output logic [3:0]    o_wr_val,
  output logic          o_carry_out,
  output logic          o_finish
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [4:0]    opcode_q;
  logic [PW-1:0] pos_q, end_q, pos_inc;
  logic          carry_q, cout_q;
  logic          accept, last;

  assign accept  = i_clk_en & i_start & ~i_abort;
  assign last    = (pos_q == end_q);
  assign pos_inc = (pos_q == PW'(NIBBLES - 1)) ? '0 : pos_q + 1'b1;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    o_busy   = 1'b0;
    o_run    = 1'b0;
    o_done   = 1'b0;
    o_wr_en  = 1'b0;
    o_wr_pos = '0;
    o_wr_val = '0;
    o_finish = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) state_nx = S_RUN;
      end
      S_RUN: begin
        o_busy   = 1'b1;
        o_run    = 1'b1;
        o_wr_en  = i_clk_en;
        o_wr_pos = pos_q;
        o_wr_val = i_calc_res_1_val;
        if (i_clk_en) begin
          if (i_abort)   state_nx = S_IDLE;
          else if (last) state_nx = S_DONE;
        end
      end
      S_DONE: begin
        o_busy   = 1'b1;
        o_run    = 1'b1;
        o_done   = 1'b1;
        // an abort landing on the DONE cycle suppresses completion
        o_finish = i_clk_en & ~i_abort;
        if (i_clk_en) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      opcode_q <= '0;
      pos_q    <= '0;
      end_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
    end else if (i_clk_en) begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            opcode_q <= i_opcode;
            pos_q    <= i_ptr_begin;
            end_q    <= i_ptr_end;
            carry_q  <= i_carry_in;
          end
        end
        S_RUN: begin
          carry_q <= i_calc_carry;
          if (!i_abort && !last) pos_q <= pos_inc;
        end
        S_DONE: begin
          if (!i_abort) cout_q <= carry_q;
        end
        default: ;
      endcase
    end
  end

  assign o_alu_opcode = opcode_q;
  assign o_calc_pos   = pos_q;
  assign o_prep_carry = carry_q;
  assign o_carry_out  = cout_q;

endmodule

// File: tb/tb_saturn_alu_sequencer.sv
// Randomized bench for saturn_alu_sequencer: an add-with-carry ALU model feeds the DUT,
// and an independent per-operation expectation list (positions, carries, sums) is checked each cycle.
module tb_saturn_alu_sequencer;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_clk_en = 1'b0;
  logic       i_start = 1'b0;
  logic       i_abort = 1'b0;
  logic [4:0] i_opcode = '0;
  logic [3:0] i_ptr_begin = '0;
  logic [3:0] i_ptr_end = '0;
  logic       i_carry_in = 1'b0;
  logic [3:0] i_calc_res_1_val;
  logic       i_calc_carry;
  logic       o_busy, o_run, o_done, o_prep_carry, o_wr_en, o_carry_out, o_finish;
  logic [4:0] o_alu_opcode;
  logic [3:0] o_calc_pos, o_wr_pos, o_wr_val;

  saturn_alu_sequencer #(.NIBBLES(16)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_clk_en(i_clk_en), .i_start(i_start),
    .i_abort(i_abort), .i_opcode(i_opcode), .i_ptr_begin(i_ptr_begin),
    .i_ptr_end(i_ptr_end), .i_carry_in(i_carry_in),
    .i_calc_res_1_val(i_calc_res_1_val), .i_calc_carry(i_calc_carry),
    .o_busy(o_busy), .o_alu_opcode(o_alu_opcode), .o_run(o_run), .o_done(o_done),
    .o_calc_pos(o_calc_pos), .o_prep_carry(o_prep_carry), .o_wr_en(o_wr_en),
    .o_wr_pos(o_wr_pos), .o_wr_val(o_wr_val), .o_carry_out(o_carry_out),
    .o_finish(o_finish)
  );

  always #5 i_clk = ~i_clk;

  // external combinational ALU: nibble add with carry over two random operands
  logic [15:0][3:0] opa, opb;
  logic [4:0]       sum;
  assign sum              = {1'b0, opa[o_calc_pos]} + {1'b0, opb[o_calc_pos]} + {4'b0, o_prep_carry};
  assign i_calc_res_1_val = sum[3:0];
  assign i_calc_carry     = sum[4];

  int   vectors = 0;
  int   miscompares = 0;
  logic last_cout = 1'b0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},   8'(o_busy), 8'h0);
    chk({tag, "_opcode"}, 8'(o_alu_opcode), 8'h0);
    chk({tag, "_run"},    8'(o_run), 8'h0);
    chk({tag, "_done"},   8'(o_done), 8'h0);
    chk({tag, "_cpos"},   8'(o_calc_pos), 8'h0);
    chk({tag, "_pcarry"}, 8'(o_prep_carry), 8'h0);
    chk({tag, "_wren"},   8'(o_wr_en), 8'h0);
    chk({tag, "_wrpos"},  8'(o_wr_pos), 8'h0);
    chk({tag, "_wrval"},  8'(o_wr_val), 8'h0);
    chk({tag, "_finish"}, 8'(o_finish), 8'h0);
    chk({tag, "_cout"},   8'(o_carry_out), 8'h0);
  endtask

  // Entered and left at posedge+#1 so consecutive calls start in the first IDLE cycle.
  task automatic run_op(input logic [3:0] b, input logic [3:0] e, input logic cin,
                        input logic [4:0] op, input int en_pct, input int abort_at,
                        input bit noise);
    int         n, k, budget;
    bit         ab;
    logic       c;
    logic [4:0] s;
    logic [3:0] pos_e[$];
    logic [3:0] val_e[$];
    logic       car_e[$];
    n = int'(4'(e - b)) + 1;
    opa = {$urandom(), $urandom()};
    opb = {$urandom(), $urandom()};
    c = cin;
    for (int i = 0; i < n; i++) begin
      logic [3:0] p;
      p = b + 4'(i);
      pos_e.push_back(p);
      car_e.push_back(c);
      s = {1'b0, opa[p]} + {1'b0, opb[p]} + {4'b0, c};
      val_e.push_back(s[3:0]);
      c = s[4];
    end
    i_start = 1'b1; i_opcode = op; i_ptr_begin = b; i_ptr_end = e;
    i_carry_in = cin; i_clk_en = 1'b1; i_abort = 1'b0;
    @(negedge i_clk);
    chk("start_busy", 8'(o_busy), 8'h0);
    chk("start_wren", 8'(o_wr_en), 8'h0);
    @(posedge i_clk); #1;
    i_start = 1'b0;
    i_opcode = 5'($urandom()); i_ptr_begin = 4'($urandom()); i_ptr_end = 4'($urandom());
    i_carry_in = 1'($urandom());
    k = 0; budget = 0; ab = 1'b0;
    while (budget < 400) begin
      budget++;
      i_clk_en = (int'($urandom_range(99)) < en_pct);
      i_abort  = (k == abort_at) && i_clk_en;
      i_start  = noise ? 1'($urandom_range(1)) : 1'b0;
      @(negedge i_clk);
      chk("busy",   8'(o_busy), 8'h1);
      chk("run",    8'(o_run), 8'h1);
      chk("opcode", 8'(o_alu_opcode), 8'(op));
      chk("cout_hold", 8'(o_carry_out), 8'(last_cout));
      if (k < n) begin
        chk("done_in_run", 8'(o_done), 8'h0);
        chk("calc_pos",    8'(o_calc_pos), 8'(pos_e[k]));
        chk("prep_carry",  8'(o_prep_carry), 8'(car_e[k]));
        chk("wr_en",       8'(o_wr_en), 8'(i_clk_en));
        chk("finish_run",  8'(o_finish), 8'h0);
        if (i_clk_en) begin
          chk("wr_pos", 8'(o_wr_pos), 8'(pos_e[k]));
          chk("wr_val", 8'(o_wr_val), 8'(val_e[k]));
        end
      end else begin
        chk("done",        8'(o_done), 8'h1);
        chk("wr_en_done",  8'(o_wr_en), 8'h0);
        chk("finish",      8'(o_finish), 8'(i_clk_en & ~i_abort));
      end
      @(posedge i_clk); #1;
      if (i_clk_en) begin
        if (i_abort) begin ab = 1'b1; break; end
        k++;
        if (k > n) break;
      end
    end
    chk("op_complete", 8'(ab || (k > n)), 8'h1);
    i_start = 1'b0; i_abort = 1'b0; i_clk_en = 1'b1;
    if (!ab) last_cout = c;
    chk("idle_after", 8'(o_busy), 8'h0);
    chk("finish_idle", 8'(o_finish), 8'h0);
    chk("carry_out", 8'(o_carry_out), 8'(last_cout));
  endtask

  initial begin
    opa = '0; opb = '0;
    // reset state, with a start request held to show it has no effect
    i_start = 1'b1; i_clk_en = 1'b1;
    repeat (2) @(negedge i_clk);
    chk_all_zero("rst");
    @(posedge i_clk); #1;
    i_start = 1'b0; i_reset = 1'b1;

    // single nibble, then wrap E..1, then full 0..F back-to-back
    run_op(4'h3, 4'h3, 1'b1, 5'h05, 100, -1, 1'b0);
    @(posedge i_clk); #1;
    run_op(4'hE, 4'h1, 1'b1, 5'h11, 100, -1, 1'b0);
    run_op(4'h0, 4'hF, 1'b0, 5'h0A, 100, -1, 1'b0);

    // clock-enable gaps, then abort on the 2nd RUN cycle with start noise
    run_op(4'h2, 4'h9, 1'b0, 5'h1F, 50, -1, 1'b0);
    run_op(4'h5, 4'hC, 1'b1, 5'h03, 100, 1, 1'b1);

    // reset mid-RUN clears outputs immediately; a fresh op then runs normally
    opa = {$urandom(), $urandom()};
    opb = '1;
    i_start = 1'b1; i_ptr_begin = 4'h4; i_ptr_end = 4'hB; i_opcode = 5'h07; i_carry_in = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("pre_rst_busy", 8'(o_busy), 8'h1);
    i_reset = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(posedge i_clk); #1;
    i_reset = 1'b1;
    last_cout = 1'b0;
    run_op(4'h7, 4'h6, 1'b1, 5'h12, 100, -1, 1'b0);

    for (int t = 0; t < 20; t++) begin
      logic [3:0] rb, re;
      int         nr, ab_at;
      rb = 4'($urandom()); re = 4'($urandom());
      nr = int'(4'(re - rb)) + 1;
      ab_at = ($urandom_range(3) == 0) ? int'($urandom_range(nr)) : -1;
      run_op(rb, re, 1'($urandom()), 5'($urandom()), int'($urandom_range(100, 40)), ab_at, 1'b1);
      if ($urandom_range(1) == 1) begin
        @(posedge i_clk); #1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
